// File: rtl/ddos_drop_gate.sv
// ddos_drop_gate: pops one blacklist verdict per packet and either forwards
// the packet downstream or silently drains it. Keeps per-verdict statistics.
module ddos_drop_gate #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_fifo_data,
  input  logic [CTRL_WIDTH-1:0] in_fifo_ctrl,
  input  logic                  in_fifo_empty,
  output logic                  in_fifo_rd_en,
  input  logic [1:0]            verdict_dout,
  input  logic                  verdict_empty,
  output logic                  verdict_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  ddos_en,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  arp_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [1:0]            gate_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;
  logic   payload_seen, payload_seen_next;
  logic   take_drop;
  logic   word_pop;
  logic   word_fwd;
  logic   is_eop;

  // Next-state, FIFO pop strobes and packet framing tracking
  always_comb begin
    state_next        = state;
    payload_seen_next = payload_seen;
    in_fifo_rd_en     = 1'b0;
    verdict_rd_en     = 1'b0;
    word_pop          = 1'b0;
    word_fwd          = 1'b0;
    take_drop         = (verdict_dout == 2'b11) && ddos_en;
    // A non-zero ctrl word only ends the packet once payload has started;
    // earlier non-zero words are module headers.
    is_eop            = (in_fifo_ctrl != '0) && payload_seen;
    case (state)
      IDLE: begin
        // Verdict is only taken once its packet data is visible, so an
        // early verdict cannot get paired with the wrong packet.
        if (!verdict_empty && !in_fifo_empty) begin
          verdict_rd_en     = 1'b1;
          payload_seen_next = 1'b0;
          state_next        = take_drop ? DROP : PASS;
        end
      end
      PASS, DROP: begin
        // Dropped packets drain at full rate regardless of backpressure.
        word_pop      = !in_fifo_empty && ((state == DROP) || out_rdy);
        word_fwd      = word_pop && (state == PASS);
        in_fifo_rd_en = word_pop;
        if (word_pop) begin
          if (in_fifo_ctrl == '0) begin
            payload_seen_next = 1'b1;
          end
          if (is_eop) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and framing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      payload_seen <= 1'b0;
    end else begin
      state        <= state_next;
      payload_seen <= payload_seen_next;
    end
  end

  // Output word register: one cycle from pop to out_wr
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= word_fwd;
      if (word_fwd) begin
        out_data <= in_fifo_data;
        out_ctrl <= in_fifo_ctrl;
      end
    end
  end

  // Statistics, bumped on the verdict pop cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
      arp_cnt  <= '0;
      err_cnt  <= '0;
    end else if (verdict_rd_en) begin
      case (verdict_dout)
        2'b01: pass_cnt <= pass_cnt + CNT_ONE;
        2'b10: arp_cnt  <= arp_cnt + CNT_ONE;
        2'b11: begin
          if (ddos_en) drop_cnt <= drop_cnt + CNT_ONE;
          else         pass_cnt <= pass_cnt + CNT_ONE;
        end
        default: err_cnt <= err_cnt + CNT_ONE;
      endcase
    end
  end

  assign gate_state = state;

endmodule

// File: tb/tb_ddos_drop_gate.sv
// Scoreboard bench for ddos_drop_gate: the bench emulates both FWFT FIFOs,
// predicts forwarded words and counter values per packet, and a separate
// monitor compares every output cycle against the prediction.
module tb_ddos_drop_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_fifo_data = '0;
  logic [7:0]  in_fifo_ctrl = '0;
  logic        in_fifo_empty = 1'b1;
  logic        in_fifo_rd_en;
  logic [1:0]  verdict_dout = '0;
  logic        verdict_empty = 1'b1;
  logic        verdict_rd_en;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        ddos_en = 1'b1;
  logic [31:0] pass_cnt, drop_cnt, arp_cnt, err_cnt;
  logic [1:0]  gate_state;

  ddos_drop_gate #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_fifo_data(in_fifo_data), .in_fifo_ctrl(in_fifo_ctrl),
    .in_fifo_empty(in_fifo_empty), .in_fifo_rd_en(in_fifo_rd_en),
    .verdict_dout(verdict_dout), .verdict_empty(verdict_empty),
    .verdict_rd_en(verdict_rd_en),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .ddos_en(ddos_en),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .arp_cnt(arp_cnt), .err_cnt(err_cnt),
    .gate_state(gate_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fwd;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  word_t      in_q[$];
  word_t      pend_q[$];
  word_t      exp_q[$];
  logic [1:0] vq[$];

  int errors = 0;
  int checks = 0;
  int m_pass = 0, m_drop = 0, m_arp = 0, m_err = 0;
  int out_count = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit stall_en = 0;
  bit hold_v = 0;
  bit pop_fwd = 0;
  bit last_rd = 0;
  bit last_vrd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: out_wr must follow a forwarded pop by exactly one cycle
  // and carry the next predicted word.
  always @(negedge clk) begin
    word_t e;
    if (!reset) begin
      checks++;
      if (out_wr !== pop_fwd) begin
        errors++;
        $display("FAIL out_wr: got %0b expected %0b (cycle %0d)", out_wr, pop_fwd, cyc);
      end
      if (out_wr === 1'b1) begin
        out_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got ctrl=%0h data=%0h expected no word", out_ctrl, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_ctrl, out_data} !== {e.ctrl, e.data}) begin
            errors++;
            $display("FAIL out_word: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                     out_ctrl, out_data, e.ctrl, e.data);
          end else begin
            $display("out word ctrl=%0h data=%0h", out_ctrl, out_data);
          end
        end
      end
    end
  end

  // One clock of FIFO emulation: present heads, sample pops, pop on the edge.
  task automatic step();
    logic rd, vrd;
    @(negedge clk);
    #1;
    cyc++;
    if (in_q.size() > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
      in_fifo_empty = 1'b0;
      in_fifo_data  = in_q[0].data;
      in_fifo_ctrl  = in_q[0].ctrl;
    end else begin
      in_fifo_empty = 1'b1;
      in_fifo_data  = {$urandom, $urandom};
      in_fifo_ctrl  = 8'($urandom);
    end
    if (vq.size() > 0 && !hold_v) begin
      verdict_empty = 1'b0;
      verdict_dout  = vq[0];
    end else begin
      verdict_empty = 1'b1;
      verdict_dout  = 2'($urandom_range(0, 3));
    end
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = 1'b0;
      2: out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
    #1;
    rd       = in_fifo_rd_en;
    vrd      = verdict_rd_en;
    last_rd  = rd;
    last_vrd = vrd;
    if (vrd) chk("verdict_pop_gated", {62'd0, in_fifo_empty, verdict_empty}, 64'd0);
    if (rd) chk("pkt_pop_nonempty", {63'd0, in_fifo_empty}, 64'd0);
    if (rd && vrd) chk("pop_both", 64'd1, 64'd0);
    if (rd && in_q.size() > 0 && in_q[0].fwd) chk("pop_respects_rdy", {63'd0, out_rdy}, 64'd1);
    @(posedge clk);
    pop_fwd = 1'b0;
    if (rd && !in_fifo_empty && in_q.size() > 0) begin
      pop_fwd = in_q[0].fwd;
      void'(in_q.pop_front());
    end
    if (vrd && !verdict_empty && vq.size() > 0) void'(vq.pop_front());
  endtask

  // Queue one packet with its verdict and predict the outcome from the rules.
  task automatic issue_pkt(input int nh, input int np, input logic [1:0] v,
                           input bit fixed, input bit hold_words);
    word_t w;
    bit    fwd;
    fwd = !(v == 2'b11 && ddos_en);
    case (v)
      2'b01: m_pass++;
      2'b10: m_arp++;
      2'b11: if (ddos_en) m_drop++; else m_pass++;
      default: m_err++;
    endcase
    vq.push_back(v);
    for (int i = 0; i < nh + np + 1; i++) begin
      w.fwd  = fwd;
      w.data = {$urandom, $urandom};
      if (i < nh)           w.ctrl = fixed ? 8'hFF : 8'($urandom_range(1, 255));
      else if (i < nh + np) w.ctrl = 8'h00;
      else                  w.ctrl = fixed ? 8'h01 : 8'($urandom_range(1, 255));
      if (hold_words) pend_q.push_back(w);
      else            in_q.push_back(w);
      if (fwd) exp_q.push_back(w);
    end
    $display("issue pkt words=%0d verdict=%0b ddos_en=%0b fwd=%0b", nh + np + 1, v, ddos_en, fwd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_q.size() > 0 || vq.size() > 0 || exp_q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_left", 64'(in_q.size() + vq.size() + exp_q.size()), 64'd0);
    step();
    step();
  endtask

  task automatic check_counts(input string tag);
    $display("counts %s pass=%0d drop=%0d arp=%0d err=%0d state=%0d",
             tag, pass_cnt, drop_cnt, arp_cnt, err_cnt, gate_state);
    chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("arp_cnt", 64'(arp_cnt), 64'(m_arp));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("gate_state_idle", 64'(gate_state), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    in_q.delete();
    vq.delete();
    exp_q.delete();
    pend_q.delete();
    in_fifo_empty = 1'b1;
    verdict_empty = 1'b1;
    m_pass = 0; m_drop = 0; m_arp = 0; m_err = 0;
    @(posedge clk);
    pop_fwd = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_wr", {63'd0, out_wr}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_arp_cnt", 64'(arp_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_state", 64'(gate_state), 64'd0);
    reset = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    int base, n;
    do_reset();

    // Plain 6-word packet, verdict pass
    rdy_mode = 0; stall_en = 0; ddos_en = 1'b1;
    issue_pkt(1, 4, 2'b01, 1'b1, 1'b0);
    drain();
    check_counts("pass");

    // Dropped packet with downstream stalled, then a passed one
    rdy_mode = 1;
    issue_pkt(1, 4, 2'b11, 1'b1, 1'b0);
    drain();
    rdy_mode = 0;
    issue_pkt(1, 4, 2'b01, 1'b1, 1'b0);
    drain();
    check_counts("drop");

    // Drop disabled, ARP and invalid verdicts back to back
    ddos_en = 1'b0;
    issue_pkt(1, 4, 2'b11, 1'b1, 1'b0);
    issue_pkt(2, 3, 2'b10, 1'b1, 1'b0);
    issue_pkt(1, 1, 2'b00, 1'b1, 1'b0);
    drain();
    check_counts("verdicts");
    ddos_en = 1'b1;

    // Data waiting, verdict withheld for 20 cycles
    hold_v = 1'b1;
    issue_pkt(1, 4, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_pop_without_verdict", {63'd0, last_rd}, 64'd0);
    end
    hold_v = 1'b0;
    step();
    chk("verdict_pop_on_arrival", {63'd0, last_vrd}, 64'd1);
    drain();

    // Verdict waiting, data arrives later
    issue_pkt(1, 2, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_verdict_pop_without_data", {63'd0, last_vrd}, 64'd0);
    end
    while (pend_q.size() > 0) in_q.push_back(pend_q.pop_front());
    drain();
    check_counts("hold");

    // out_rdy toggling 1,0,0,1
    rdy_mode = 2;
    issue_pkt(1, 4, 2'b01, 1'b1, 1'b0);
    issue_pkt(2, 5, 2'b10, 1'b0, 1'b0);
    drain();
    check_counts("toggle");

    // Randomized batches; ddos_en only changes between drained batches
    for (int b = 0; b < 5; b++) begin
      ddos_en  = 1'($urandom_range(0, 1));
      rdy_mode = 3;
      stall_en = 1'b1;
      for (int p = 0; p < 8; p++) begin
        issue_pkt($urandom_range(1, 2), $urandom_range(1, 5), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        if ($urandom_range(0, 1) == 1) step();
      end
      drain();
      check_counts("random");
    end

    // Reset in the middle of a forwarded packet
    rdy_mode = 0; stall_en = 0; ddos_en = 1'b1;
    issue_pkt(1, 4, 2'b01, 1'b1, 1'b0);
    base = out_count;
    n = 0;
    while (out_count < base + 3 && n < 100) begin
      step();
      n++;
    end
    chk("reached_word3", 64'(out_count >= base + 3), 64'd1);
    do_reset();
    issue_pkt(1, 4, 2'b10, 1'b1, 1'b0);
    drain();
    check_counts("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
